// File: rtl/apb_soc_ctrl_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_soc_ctrl_mc_pkg
// Description : Shared constants and types for the multi-cluster SoC control
//               block: global register offsets, the cluster block layout and
//               the per-cluster power sequencer state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package apb_soc_ctrl_mc_pkg;

    // Global register byte offsets (address region below the cluster base)
    localparam logic [7:0] c_ofs_info       = 8'h00;
    localparam logic [7:0] c_ofs_fcboot     = 8'h04;
    localparam logic [7:0] c_ofs_fcfetch    = 8'h08;
    localparam logic [7:0] c_ofs_corestatus = 8'h0C;
    localparam logic [7:0] c_ofs_jtagreg    = 8'h10;
    localparam logic [7:0] c_ofs_bootsel    = 8'h14;
    localparam logic [7:0] c_ofs_clksel     = 8'h18;

    // Cluster register block layout
    localparam int unsigned c_cl_base   = 32'h100;
    localparam int unsigned c_cl_stride = 32'h20;
    localparam int unsigned c_cl_max    = 8;

    // Register offsets inside one cluster block
    localparam logic [4:0] c_cl_ofs_ctrl    = 5'h00;
    localparam logic [4:0] c_cl_ofs_status  = 5'h04;
    localparam logic [4:0] c_cl_ofs_boot_lo = 5'h08;
    localparam logic [4:0] c_cl_ofs_boot_hi = 5'h0C;
    localparam logic [4:0] c_cl_ofs_irq     = 5'h10;

    typedef enum logic [2:0] {
        CL_OFF     = 3'd0,
        CL_PWR_ON  = 3'd1,
        CL_RST_REL = 3'd2,
        CL_RUN     = 3'd3,
        CL_PWR_DN  = 3'd4
    } cl_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_soc_ctrl_mc_cluster_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : cluster_pwr_seq
// Description : Power-up / power-down sequencer for one cluster. Walks
//               OFF -> PWR_ON -> RST_REL -> RUN while req_on is high and
//               PWR_DN -> OFF once it drops. Outputs are decoded from the
//               registered state only.
// Ports       : HCLK, HRESETn (async, active-low)
//               req_on              - software power request
//               pow/byp/rstn/fetch  - cluster power, clock bypass, reset_n,
//                                     fetch enable
//               state               - current sequencer state
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_pwr_seq
    import apb_soc_ctrl_mc_pkg::*;
#(
    parameter int unsigned PWR_DLY = 16,
    parameter int unsigned RST_DLY = 8
) (
    input  logic      HCLK,
    input  logic      HRESETn,
    input  logic      req_on,
    output logic      pow,
    output logic      byp,
    output logic      rstn,
    output logic      fetch,
    output cl_state_e state
);

    localparam int unsigned MAX_DLY = (PWR_DLY > RST_DLY) ? PWR_DLY : RST_DLY;
    localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);
    // Last count value of each timed state: a state timed for N cycles
    // leaves when the counter (cleared on entry) reaches N-1.
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DLY - 1);

    cl_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= CL_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        pow         = 1'b0;
        byp         = 1'b1;
        rstn        = 1'b0;
        fetch       = 1'b0;
        unique case (r_state)
            CL_OFF: begin
                if (req_on) w_state_nxt = CL_PWR_ON;
            end
            CL_PWR_ON: begin
                pow = 1'b1;
                if (!req_on)                w_state_nxt = CL_PWR_DN;
                else if (r_cnt == PWR_LAST) w_state_nxt = CL_RST_REL;
            end
            CL_RST_REL: begin
                pow  = 1'b1;
                byp  = 1'b0;
                rstn = 1'b1;
                if (!req_on)                w_state_nxt = CL_PWR_DN;
                else if (r_cnt == RST_LAST) w_state_nxt = CL_RUN;
            end
            CL_RUN: begin
                pow   = 1'b1;
                byp   = 1'b0;
                rstn  = 1'b1;
                fetch = 1'b1;
                if (!req_on) w_state_nxt = CL_PWR_DN;
            end
            CL_PWR_DN: begin
                // Shutdown always runs to completion; OFF re-evaluates req_on.
                pow = 1'b1;
                if (r_cnt == PWR_LAST) w_state_nxt = CL_OFF;
            end
            default: begin
                w_state_nxt = CL_OFF;
            end
        endcase

        // Counter restarts on every state change and idles in untimed states.
        if (w_state_nxt != r_state)
            w_cnt_nxt = '0;
        else if (r_state == CL_OFF || r_state == CL_RUN)
            w_cnt_nxt = r_cnt;
        else
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/apb_soc_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : apb_soc_ctrl_mc
// Description : APB SoC control register file for multi-cluster systems.
//               Global FC boot/fetch, core status, JTAG mailbox, bootsel and
//               clock-select registers, plus per cluster a power sequencer,
//               64-bit boot address and IRQ register.
// Ports       : HCLK, HRESETn (async, active-low)
//               PADDR/PWDATA/PWRITE/PSEL/PENABLE/PRDATA/PREADY/PSLVERR - APB
//               sel_clk_i, bootsel_*, fc_fetch_en_*, soc_jtag_reg_i - status in
//               soc_jtag_reg_o, fc_bootaddr_o, fc_fetchen_o, eoc_o - FC control
//               cluster_*_o - per-cluster power/bypass/reset/fetch/irq/boot
// Revision    : 1.0 - initial release
// ============================================================================
module apb_soc_ctrl_mc
    import apb_soc_ctrl_mc_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NB_CLUSTERS    = 2,
    parameter int unsigned NB_CORES       = 8,
    parameter int unsigned JTAG_REG_SIZE  = 8,
    parameter logic [31:0] FC_BOOT_DEF    = 32'h1A000080,
    parameter int unsigned PWR_DLY        = 16,
    parameter int unsigned RST_DLY        = 8,
    parameter int unsigned IRQ_PULSE      = 1
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]       PADDR,
    input  logic [31:0]                     PWDATA,
    input  logic                            PWRITE,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    output logic [31:0]                     PRDATA,
    output logic                            PREADY,
    output logic                            PSLVERR,
    input  logic                            sel_clk_i,
    input  logic                            bootsel_valid_i,
    input  logic [1:0]                      bootsel_i,
    input  logic                            fc_fetch_en_valid_i,
    input  logic                            fc_fetch_en_i,
    input  logic [JTAG_REG_SIZE-1:0]        soc_jtag_reg_i,
    output logic [JTAG_REG_SIZE-1:0]        soc_jtag_reg_o,
    output logic [31:0]                     fc_bootaddr_o,
    output logic                            fc_fetchen_o,
    output logic                            eoc_o,
    output logic [NB_CLUSTERS-1:0]          cluster_pow_o,
    output logic [NB_CLUSTERS-1:0]          cluster_byp_o,
    output logic [NB_CLUSTERS-1:0]          cluster_rstn_o,
    output logic [NB_CLUSTERS-1:0]          cluster_fetch_enable_o,
    output logic [NB_CLUSTERS-1:0]          cluster_irq_o,
    output logic [NB_CLUSTERS-1:0][63:0]    cluster_boot_addr_o
);

    // ------------------------------------------------------------------
    // Global registers
    // ------------------------------------------------------------------
    logic [31:0]              r_fcboot;
    logic                     r_fcfetch;
    logic [31:0]              r_corestatus;
    logic [JTAG_REG_SIZE-1:0] r_jtag_out;
    logic [JTAG_REG_SIZE-1:0] r_jtag_sync1, r_jtag_sync2;
    logic [1:0]               r_bootsel;

    // Per-cluster register views, driven from inside the generate loop
    logic        w_cl_req     [NB_CLUSTERS];
    logic [31:0] w_cl_boot_lo [NB_CLUSTERS];
    logic [31:0] w_cl_boot_hi [NB_CLUSTERS];
    logic        w_cl_irq     [NB_CLUSTERS];
    cl_state_e   w_cl_state   [NB_CLUSTERS];

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    logic [31:0]            w_addr, w_rdata;
    logic [7:0]             w_glb_ofs;
    logic [2:0]             w_cl_idx;
    logic [4:0]             w_cl_ofs;
    logic                   w_is_glb, w_is_cl;
    logic                   w_access, w_wr, w_err, w_wr_ok;
    logic                   w_hit_fcboot, w_hit_fcfetch, w_hit_corestatus, w_hit_jtag;
    logic [NB_CLUSTERS-1:0] w_cl_sel;

    assign w_addr    = 32'(PADDR);
    assign w_glb_ofs = w_addr[7:0];
    assign w_cl_idx  = w_addr[7:5];
    assign w_cl_ofs  = w_addr[4:0];
    assign w_is_glb  = (w_addr < c_cl_base);
    assign w_is_cl   = (w_addr >= c_cl_base) && (w_addr < c_cl_base + c_cl_max * c_cl_stride);
    assign w_access  = PSEL & PENABLE;
    assign w_wr      = w_access & PWRITE;
    assign w_wr_ok   = w_wr & ~w_err;

    always_comb begin
        w_rdata          = '0;
        w_err            = 1'b0;
        w_hit_fcboot     = 1'b0;
        w_hit_fcfetch    = 1'b0;
        w_hit_corestatus = 1'b0;
        w_hit_jtag       = 1'b0;
        w_cl_sel         = '0;
        if (w_is_glb) begin
            case (w_glb_ofs)
                c_ofs_info: begin
                    w_rdata = {16'(NB_CORES), 16'(NB_CLUSTERS)};
                    w_err   = PWRITE;
                end
                c_ofs_fcboot: begin
                    w_rdata      = r_fcboot;
                    w_hit_fcboot = 1'b1;
                end
                c_ofs_fcfetch: begin
                    w_rdata       = {31'd0, r_fcfetch};
                    w_hit_fcfetch = 1'b1;
                end
                c_ofs_corestatus: begin
                    w_rdata          = r_corestatus;
                    w_hit_corestatus = 1'b1;
                end
                c_ofs_jtagreg: begin
                    w_rdata    = 32'({r_jtag_sync2, r_jtag_out});
                    w_hit_jtag = 1'b1;
                end
                c_ofs_bootsel: begin
                    w_rdata = {30'd0, r_bootsel};
                    w_err   = PWRITE;
                end
                c_ofs_clksel: begin
                    w_rdata = {31'd0, sel_clk_i};
                    w_err   = PWRITE;
                end
                default: w_err = 1'b1;
            endcase
        end else if (w_is_cl) begin
            // Cluster slots beyond NB_CLUSTERS never match below and stay in error.
            w_err = 1'b1;
            for (int c = 0; c < NB_CLUSTERS; c++) begin
                if (w_cl_idx == 3'(c)) begin
                    w_err       = 1'b0;
                    w_cl_sel[c] = 1'b1;
                    case (w_cl_ofs)
                        c_cl_ofs_ctrl: w_rdata = {31'd0, w_cl_req[c]};
                        c_cl_ofs_status: begin
                            w_rdata = {23'd0,
                                       (w_cl_state[c] != CL_OFF) && (w_cl_state[c] != CL_RUN),
                                       5'd0, w_cl_state[c]};
                            w_err   = PWRITE;
                        end
                        // Boot address is locked once the cluster leaves OFF.
                        c_cl_ofs_boot_lo: begin
                            w_rdata = w_cl_boot_lo[c];
                            w_err   = PWRITE && (w_cl_state[c] != CL_OFF);
                        end
                        c_cl_ofs_boot_hi: begin
                            w_rdata = w_cl_boot_hi[c];
                            w_err   = PWRITE && (w_cl_state[c] != CL_OFF);
                        end
                        c_cl_ofs_irq: w_rdata = (IRQ_PULSE != 0) ? 32'd0 : {31'd0, w_cl_irq[c]};
                        default:      w_err   = 1'b1;
                    endcase
                end
            end
        end else begin
            w_err = 1'b1;
        end
    end

    assign PRDATA  = w_rdata;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & w_err;

    // ------------------------------------------------------------------
    // Global register state
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fcboot     <= FC_BOOT_DEF;
            r_fcfetch    <= 1'b0;
            r_corestatus <= '0;
            r_jtag_out   <= '0;
            r_jtag_sync1 <= '0;
            r_jtag_sync2 <= '0;
            r_bootsel    <= '0;
        end else begin
            if (w_wr_ok && w_hit_fcboot)     r_fcboot     <= PWDATA;
            if (w_wr_ok && w_hit_corestatus) r_corestatus <= PWDATA;
            if (w_wr_ok && w_hit_jtag)       r_jtag_out   <= PWDATA[JTAG_REG_SIZE-1:0];
            // The hardware strobe takes priority over a concurrent APB write.
            if (fc_fetch_en_valid_i)
                r_fcfetch <= fc_fetch_en_i;
            else if (w_wr_ok && w_hit_fcfetch)
                r_fcfetch <= PWDATA[0];
            if (bootsel_valid_i) r_bootsel <= bootsel_i;
            r_jtag_sync1 <= soc_jtag_reg_i;
            r_jtag_sync2 <= r_jtag_sync1;
        end
    end

    assign soc_jtag_reg_o = r_jtag_out;
    assign fc_bootaddr_o  = r_fcboot;
    assign fc_fetchen_o   = r_fcfetch;
    assign eoc_o          = r_corestatus[31];

    // ------------------------------------------------------------------
    // Per-cluster registers and sequencers
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NB_CLUSTERS; c++) begin : g_cluster
        logic        r_req;
        logic [31:0] r_boot_lo, r_boot_hi;
        logic        r_irq;
        logic        w_cl_wr;

        assign w_cl_wr = w_wr_ok & w_cl_sel[c];

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                r_req     <= 1'b0;
                r_boot_lo <= '0;
                r_boot_hi <= '0;
            end else if (w_cl_wr) begin
                if (w_cl_ofs == c_cl_ofs_ctrl)    r_req     <= PWDATA[0];
                if (w_cl_ofs == c_cl_ofs_boot_lo) r_boot_lo <= PWDATA;
                if (w_cl_ofs == c_cl_ofs_boot_hi) r_boot_hi <= PWDATA;
            end
        end

        if (IRQ_PULSE != 0) begin : g_irq_pulse
            // Self-clearing: high for exactly the cycle after the write.
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) r_irq <= 1'b0;
                else          r_irq <= w_cl_wr && (w_cl_ofs == c_cl_ofs_irq) && PWDATA[0];
            end
        end else begin : g_irq_level
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn)                             r_irq <= 1'b0;
                else if (w_cl_wr && w_cl_ofs == c_cl_ofs_irq) r_irq <= PWDATA[0];
            end
        end

        cluster_pwr_seq #(
            .PWR_DLY (PWR_DLY),
            .RST_DLY (RST_DLY)
        ) u_pwr_seq (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .req_on  (r_req),
            .pow     (cluster_pow_o[c]),
            .byp     (cluster_byp_o[c]),
            .rstn    (cluster_rstn_o[c]),
            .fetch   (cluster_fetch_enable_o[c]),
            .state   (w_cl_state[c])
        );

        assign w_cl_req[c]            = r_req;
        assign w_cl_boot_lo[c]        = r_boot_lo;
        assign w_cl_boot_hi[c]        = r_boot_hi;
        assign w_cl_irq[c]            = r_irq;
        assign cluster_irq_o[c]       = r_irq;
        assign cluster_boot_addr_o[c] = {r_boot_hi, r_boot_lo};
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_soc_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_soc_ctrl_mc
// Description : Self-checking bench for apb_soc_ctrl_mc (PWR_DLY=4,
//               RST_DLY=2, two clusters, pulse IRQ). APB expectations are
//               queued by the stimulus and consumed by a monitor on every
//               access phase; sideband outputs are checked at fixed cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_soc_ctrl_mc;

    localparam int AW  = 12;
    localparam int NCL = 2;
    localparam int J   = 8;

    logic                 HCLK = 1'b0;
    logic                 HRESETn;
    logic [AW-1:0]        PADDR;
    logic [31:0]          PWDATA;
    logic                 PWRITE, PSEL, PENABLE;
    logic [31:0]          PRDATA;
    logic                 PREADY, PSLVERR;
    logic                 sel_clk_i, bootsel_valid_i, fc_fetch_en_valid_i, fc_fetch_en_i;
    logic [1:0]           bootsel_i;
    logic [J-1:0]         soc_jtag_reg_i, soc_jtag_reg_o;
    logic [31:0]          fc_bootaddr_o;
    logic                 fc_fetchen_o, eoc_o;
    logic [NCL-1:0]       pow, byp, rstn, fetch, irq;
    logic [NCL-1:0][63:0] boot_addr;

    apb_soc_ctrl_mc #(
        .APB_ADDR_WIDTH (AW),
        .NB_CLUSTERS    (NCL),
        .NB_CORES       (8),
        .JTAG_REG_SIZE  (J),
        .FC_BOOT_DEF    (32'h1A000080),
        .PWR_DLY        (4),
        .RST_DLY        (2),
        .IRQ_PULSE      (1)
    ) dut (
        .HCLK                   (HCLK),
        .HRESETn                (HRESETn),
        .PADDR                  (PADDR),
        .PWDATA                 (PWDATA),
        .PWRITE                 (PWRITE),
        .PSEL                   (PSEL),
        .PENABLE                (PENABLE),
        .PRDATA                 (PRDATA),
        .PREADY                 (PREADY),
        .PSLVERR                (PSLVERR),
        .sel_clk_i              (sel_clk_i),
        .bootsel_valid_i        (bootsel_valid_i),
        .bootsel_i              (bootsel_i),
        .fc_fetch_en_valid_i    (fc_fetch_en_valid_i),
        .fc_fetch_en_i          (fc_fetch_en_i),
        .soc_jtag_reg_i         (soc_jtag_reg_i),
        .soc_jtag_reg_o         (soc_jtag_reg_o),
        .fc_bootaddr_o          (fc_bootaddr_o),
        .fc_fetchen_o           (fc_fetchen_o),
        .eoc_o                  (eoc_o),
        .cluster_pow_o          (pow),
        .cluster_byp_o          (byp),
        .cluster_rstn_o         (rstn),
        .cluster_fetch_enable_o (fetch),
        .cluster_irq_o          (irq),
        .cluster_boot_addr_o    (boot_addr)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        logic        cmp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Called 1 ns after a rising edge: setup phase now, access phase next
    // cycle; returns 1 ns into the cycle after the access phase.
    task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input logic strobe);
        exp_t e;
        e.addr  = addr;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cmp   = !wr;
        sb_q.push_back(e);
        PADDR   = addr[AW-1:0];
        PWRITE  = wr;
        PWDATA  = wdata;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        if (strobe) begin
            fc_fetch_en_valid_i = 1'b1;
            fc_fetch_en_i       = 1'b0;
        end
        step(1);
        PSEL                = 1'b0;
        PENABLE             = 1'b0;
        PWRITE              = 1'b0;
        fc_fetch_en_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        apb(addr, 1'b1, data, 32'd0, exp_err, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
        apb(addr, 1'b0, 32'd0, exp_rd, exp_err, 1'b0);
    endtask

    // Monitor: every APB access phase consumes one queued expectation.
    always @(negedge HCLK) begin : mon
        exp_t e;
        if (PSEL && PENABLE) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL apb_unexpected: access at %h with no expectation", PADDR);
            end else begin
                e = sb_q.pop_front();
                if (PSLVERR !== e.err || PREADY !== 1'b1 || (e.cmp && PRDATA !== e.rdata)) begin
                    failures++;
                    $display("FAIL apb@%h: got err=%b rdata=%h ready=%b expected err=%b rdata=%h (rdata checked=%b)",
                             e.addr, PSLVERR, PRDATA, PREADY, e.err, e.rdata, e.cmp);
                end
            end
        end
    end

    initial begin
        HRESETn             = 1'b0;
        PADDR               = '0;
        PWDATA              = '0;
        PWRITE              = 1'b0;
        PSEL                = 1'b0;
        PENABLE             = 1'b0;
        sel_clk_i           = 1'b0;
        bootsel_valid_i     = 1'b0;
        bootsel_i           = 2'd0;
        fc_fetch_en_valid_i = 1'b0;
        fc_fetch_en_i       = 1'b0;
        soc_jtag_reg_i      = '0;
        step(3);
        HRESETn = 1'b1;

        // Reset state
        chk("rst_pow",    pow,   2'b00);
        chk("rst_byp",    byp,   2'b11);
        chk("rst_rstn",   rstn,  2'b00);
        chk("rst_fetch",  fetch, 2'b00);
        chk("rst_irq",    irq,   2'b00);
        chk("rst_fcboot", fc_bootaddr_o, 32'h1A000080);
        chk("rst_fcfetch", fc_fetchen_o, 1'b0);
        rd(32'h004, 32'h1A000080, 1'b0);
        rd(32'h000, 32'h00080002, 1'b0);

        // Power-up of cluster 0: write access at cycle T
        wr(32'h100, 32'd1, 1'b0);           // now T+1
        chk("up_pow_T1", pow, 2'b00);
        step(1);                             // T+2
        chk("up_pow_T2", pow, 2'b01);
        chk("up_byp_T2", byp, 2'b11);
        chk("up_rstn_T2", rstn, 2'b00);
        step(3);                             // T+5
        chk("up_rstn_T5", rstn, 2'b00);
        step(1);                             // T+6
        chk("up_rstn_T6", rstn, 2'b01);
        chk("up_byp_T6", byp, 2'b10);
        chk("up_fetch_T6", fetch, 2'b00);
        step(1);                             // T+7
        chk("up_fetch_T7", fetch, 2'b00);
        step(1);                             // T+8
        chk("up_fetch_T8", fetch, 2'b01);
        rd(32'h104, 32'h00000003, 1'b0);

        // Boot address locked while running, writable once OFF
        wr(32'h108, 32'h1C008080, 1'b1);
        rd(32'h108, 32'h00000000, 1'b0);
        chk("boot_locked", boot_addr[0], 64'd0);
        wr(32'h100, 32'd0, 1'b0);
        step(8);
        rd(32'h104, 32'h00000000, 1'b0);
        chk("off_pow", pow, 2'b00);
        wr(32'h108, 32'h1C008080, 1'b0);
        wr(32'h10C, 32'h00000001, 1'b0);
        rd(32'h108, 32'h1C008080, 1'b0);
        chk("boot_addr0", boot_addr[0], 64'h00000001_1C008080);

        // Abort during PWR_ON, re-request inside PWR_DN
        wr(32'h100, 32'd1, 1'b0);           // access T, now T+1
        wr(32'h100, 32'd0, 1'b0);           // access T+2, now T+3 (PWR_ON)
        chk("ab_pow_pwron", pow, 2'b01);
        chk("ab_rstn_pwron", rstn, 2'b00);
        rd(32'h104, 32'h00000104, 1'b0);    // access T+4: PWR_DN, busy
        wr(32'h100, 32'd1, 1'b0);           // access T+6, now T+7 (last PWR_DN)
        chk("ab_pow_dn_end", pow, 2'b01);
        chk("ab_byp_dn_end", byp, 2'b11);
        step(1);                             // T+8: OFF
        chk("ab_pow_off", pow, 2'b00);
        step(1);                             // T+9: PWR_ON again
        chk("ab_pow_reon", pow, 2'b01);

        // IRQ pulse and error decode
        chk("irq_idle", irq, 2'b00);
        wr(32'h130, 32'd1, 1'b0);
        chk("irq_pulse", irq, 2'b10);
        step(1);
        chk("irq_cleared", irq, 2'b00);
        rd(32'h130, 32'h0, 1'b0);
        rd(32'h160, 32'h0, 1'b1);
        wr(32'h140, 32'd1, 1'b1);
        wr(32'h114, 32'd5, 1'b1);
        rd(32'h01C, 32'h0, 1'b1);
        rd(32'h200, 32'h0, 1'b1);
        wr(32'h000, 32'd5, 1'b1);
        wr(32'h104, 32'd0, 1'b1);

        // Fetch-enable strobe beats a concurrent APB write
        wr(32'h008, 32'd1, 1'b0);
        chk("fetch_wr", fc_fetchen_o, 1'b1);
        apb(32'h008, 1'b1, 32'd1, 32'd0, 1'b0, 1'b1);
        chk("fetch_strobe_wins", fc_fetchen_o, 1'b0);
        rd(32'h008, 32'h0, 1'b0);

        // JTAG mailbox and its input synchroniser
        wr(32'h010, 32'h0000003C, 1'b0);
        chk("jtag_out", soc_jtag_reg_o, 8'h3C);
        soc_jtag_reg_i = 8'hA5;
        rd(32'h010, 32'h0000003C, 1'b0);    // only one flop loaded yet
        rd(32'h010, 32'h0000A53C, 1'b0);

        // Bootsel strobe, CLKSEL, CORESTATUS/EOC
        bootsel_i       = 2'd2;
        bootsel_valid_i = 1'b1;
        step(1);
        bootsel_valid_i = 1'b0;
        rd(32'h014, 32'h2, 1'b0);
        wr(32'h014, 32'h1, 1'b1);
        sel_clk_i = 1'b1;
        rd(32'h018, 32'h1, 1'b0);
        wr(32'h00C, 32'h80000001, 1'b0);
        chk("eoc", eoc_o, 1'b1);
        rd(32'h00C, 32'h80000001, 1'b0);
        wr(32'h004, 32'h12345678, 1'b0);
        chk("fcboot_wr", fc_bootaddr_o, 32'h12345678);

        // Asynchronous reset in the middle of a sequence
        step(1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_pow", pow, 2'b00);
        chk("arst_byp", byp, 2'b11);
        chk("arst_fcboot", fc_bootaddr_o, 32'h1A000080);
        chk("arst_eoc", eoc_o, 1'b0);
        step(2);
        HRESETn = 1'b1;
        rd(32'h100, 32'h0, 1'b0);
        step(1);
        chk("arst_pow_held", pow, 2'b00);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_soc_ctrl_mc.md
Name: apb_soc_ctrl_mc

Overview:
Parametrised APB SoC control block that is the multi-cluster successor of the single-cluster SoC control register file. Holds FC boot/fetch, core status/EOC, JTAG mailbox and bootsel registers. Adds one hardware power-up/down sequencer per cluster and per-cluster boot address and IRQ registers. Sits on the SoC APB bus and drives FC boot control plus every cluster's power, bypass, reset, fetch-enable and IRQ lines.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; must be >=10.
NB_CLUSTERS, 2, number of clusters, 1..8.
NB_CORES, 8, cores per cluster; reported in INFO.
JTAG_REG_SIZE, 8, JTAG mailbox width, 1..16.
FC_BOOT_DEF, 32'h1A000080, reset value of FCBOOT.
PWR_DLY, 16, cycles power is held before reset release, and before power-off on shutdown; >=1.
RST_DLY, 8, cycles between reset release and fetch enable; >=1.
IRQ_PULSE, 1, 1 = IRQ write gives a one-cycle pulse; 0 = IRQ is a RW level.

Ports:
HCLK  in  1  clock
HRESETn  in  1  async active-low reset
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  32  write data
PWRITE, PSEL, PENABLE  in  1 each  APB controls
PRDATA  out  32  read data
PREADY  out  1  tied 1
PSLVERR  out  1  access error
sel_clk_i  in  1  clock select status
bootsel_valid_i  in  1  bootsel load strobe
bootsel_i  in  2  bootsel value
fc_fetch_en_valid_i  in  1  fetch-enable load strobe
fc_fetch_en_i  in  1  fetch-enable value
soc_jtag_reg_i  in  JTAG_REG_SIZE  JTAG mailbox in
soc_jtag_reg_o  out  JTAG_REG_SIZE  JTAG mailbox out
fc_bootaddr_o  out  32  FC boot address
fc_fetchen_o  out  1  FC fetch enable
eoc_o  out  1  CORESTATUS[31]
cluster_pow_o, cluster_byp_o, cluster_rstn_o, cluster_fetch_enable_o, cluster_irq_o  out  NB_CLUSTERS each  per-cluster controls
cluster_boot_addr_o  out  NB_CLUSTERS x 64  per-cluster boot address

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK.
- APB timing:
  - Zero wait states.
  - Write commits on the PSEL&PENABLE&PWRITE cycle; register visible the next cycle.
  - PRDATA is combinational from PADDR.
  - PSLVERR is combinational, asserted only when PSEL&PENABLE.
- Global map (byte offsets):
  - 0x00 INFO RO {NB_CORES[15:0], NB_CLUSTERS[15:0]}.
  - 0x04 FCBOOT RW, reset FC_BOOT_DEF.
  - 0x08 FCFETCH RW bit0, reset 0.
  - 0x0C CORESTATUS RW 32, reset 0.
  - 0x10 JTAGREG: [J-1:0] RW out value; [2J-1:J] RO input after a 2-flop synchroniser; reset 0.
  - 0x14 BOOTSEL RO [1:0], reset 0.
  - 0x18 CLKSEL RO {31'b0, sel_clk_i}.
- Cluster c block at 0x100 + 0x20*c:
  - +0x00 CTRL RW bit0 req_on, reset 0.
  - +0x04 STATUS RO {busy[8], state[2:0]}; busy = state not in {OFF, RUN}.
  - +0x08 BOOT_LO RW, reset 0.
  - +0x0C BOOT_HI RW, reset 0.
  - +0x10 IRQ. IRQ_PULSE=1: write bit0=1 gives cluster_irq_o[c]=1 for exactly the next cycle; reads 0. IRQ_PULSE=0: RW level, reset 0.
- PSLVERR=1 and no state change for:
  - unmapped offsets, including cluster +0x14..+0x1C and c >= NB_CLUSTERS;
  - writes to RO registers;
  - writes to BOOT_LO/HI while cluster state != OFF.
- Unmapped reads return 0.
- fc_fetch_en_valid_i / bootsel_valid_i load FCFETCH / BOOTSEL. A valid strobe wins over a same-cycle APB write to FCFETCH.
- Sequencer per cluster. State encoding: OFF=0, PWR_ON=1, RST_REL=2, RUN=3, PWR_DN=4. Outputs are Moore-decoded from registered state:
  - OFF: pow=0, byp=1, rstn=0, fetch=0. Moves to PWR_ON when req_on=1.
  - PWR_ON: pow=1, byp=1, rstn=0. Counts PWR_DLY cycles, then RST_REL.
  - RST_REL: pow=1, byp=0, rstn=1, fetch=0. Counts RST_DLY cycles, then RUN.
  - RUN: pow=1, byp=0, rstn=1, fetch=1.
  - req_on=0 in PWR_ON, RST_REL or RUN moves to PWR_DN next cycle.
  - PWR_DN: pow=1, byp=1, rstn=0, fetch=0. Counts PWR_DLY cycles, then OFF.
  - req_on toggled during PWR_DN does not abort it; the OFF state then re-evaluates req_on.
- Timing: a CTRL write at cycle T gives pow rising at T+2, rstn at T+2+PWR_DLY, fetch at T+2+PWR_DLY+RST_DLY.
- Counter: width $clog2(max(PWR_DLY,RST_DLY)+1); cleared on every state entry.
- Reset mid-sequence forces OFF and all reset values immediately.

Decomposition:
- Package apb_soc_ctrl_mc_pkg holds:
  - register offset localparams;
  - cluster block stride 0x20 and base 0x100;
  - cl_state_e enum (3-bit, values above).
- Sub-module cluster_pwr_seq: one FSM plus counter per cluster, instantiated in a generate loop.
  - Inputs: req_on.
  - Outputs: pow, byp, rstn, fetch, state.

Test Plan:
- Reset (PWR_DLY=4, RST_DLY=2) -> FCBOOT reads 0x1A000080, INFO reads 0x00080002, all clusters pow=0 byp=1 rstn=0.
- Write CTRL0=1 at T -> pow0=1 at T+2, rstn0=1 and byp0=0 at T+6, fetch0=1 at T+8; STATUS reads busy until RUN, then 0x003.
- In RUN, write BOOT_LO0=0x1C008080 -> PSLVERR=1, value unchanged. After CTRL0=0 and reaching OFF, same write -> PSLVERR=0, readback 0x1C008080.
- Write CTRL0=0 during PWR_ON, then CTRL0=1 inside PWR_DN -> PWR_DN completes 4 cycles, OFF for 1 cycle, then PWR_ON again.
- IRQ_PULSE=1, write IRQ1=1 -> cluster_irq_o=2'b10 for exactly one cycle. Read of 0x160 (c=3 >= NB_CLUSTERS) -> PSLVERR=1, PRDATA=0.
- fc_fetch_en_valid_i=1 with fc_fetch_en_i=0 in the same cycle as an APB write FCFETCH=1 -> fc_fetchen_o=0. soc_jtag_reg_i=0xA5 -> JTAGREG[15:8]=0xA5 after 2 cycles.
